off_on_seq: RTL and testbench
=============================

# off_on_seq

Parametrised successor to the single-shot on/off gate used in the NMR pulse path. It drives a gate output `off_on` either as a level gate held until a stop request or as a programmable train of `n_pulse` timed ON/OFF pulses. It reports completion through a registered `state_over` flag and a pulse counter. It sits between the acquisition sequencer, which arms, stops and programs it, and the transmitter/receiver switch drivers.

## Interface
- `CNT_W`, default 16: width of the ON/OFF duration fields and timer.
- `NP_W`, default 8: width of the pulse-count field and `pulse_cnt`.
- `clk_sys`, in, 1: system clock; all logic on its rising edge.
- `rst`, in, 1: reset, synchronous, active-high; highest priority.
- `arm`, in, 1: level enable. Low forces IDLE; high starts and holds a sequence.
- `stop`, in, 1: abort/terminate request, sampled every cycle.
- `mode`, in, 1: 0 = level gate (ON until `stop`), 1 = timed pulse train.
- `on_len`, in, `CNT_W`: ON duration in cycles; 0 is treated as 1.
- `off_len`, in, `CNT_W`: OFF gap in cycles; 0 is treated as 1.
- `n_pulse`, in, `NP_W`: number of ON phases; 0 is treated as 1.
- `off_on`, out, 1: gate output, registered.
- `state_over`, out, 1: 1 while not finished, 0 once DONE is reached; registered.
- `done`, out, 1: one-cycle pulse on entry to DONE.
- `busy`, out, 1: high in ON or OFF.
- `pulse_cnt`, out, `NP_W`: completed ON phases in the current sequence.

## Operation
- States: IDLE, ON, OFF, DONE.
- Outputs are registered from the next state, so they update in the same edge as the state register.
- Reset (`rst`=1) or `arm`=0: next state is IDLE.
  - Outputs: `off_on`=0, `state_over`=1, `done`=0, `busy`=0, `pulse_cnt`=0.
- IDLE→ON when `arm`=1 and `stop`=0. On that edge, latch `mode`, `on_len`, `off_len` and `n_pulse` (zero-substituted) and load the timer with `on_len`−1. Inputs changed mid-sequence have no effect.
- IDLE with `arm`=1 and `stop`=1: go directly to DONE with no pulse.
- ON, `mode`=0: stay in ON until `stop`=1, then go to DONE. `pulse_cnt` goes to 1 on exit.
- ON, `mode`=1: decrement the timer each cycle. At timer 0:
  - increment `pulse_cnt`;
  - if `pulse_cnt`+1 equals `n_pulse`, go to DONE (no trailing OFF);
  - otherwise go to OFF and load the timer with `off_len`−1.
- OFF: decrement the timer. At 0, go to ON and load `on_len`−1.
- `stop`=1 in ON or OFF: go to DONE on the next edge. `off_on` drops on the same edge. `pulse_cnt` counts the aborted ON phase as completed.
- DONE: `off_on`=0, `state_over`=0. Stay until `arm`=0 or `rst`. Re-arming requires `arm` to go low and then high again.
- Priority: `rst` > `arm`=0 > `stop` > timer expiry.
- `pulse_cnt` saturates at 2^`NP_W`−1; it never wraps.

## Timing
- Latency: `arm` sampled high at edge k gives `off_on`=1 after edge k.
- In timed mode, each ON phase holds `off_on`=1 for exactly `on_len` cycles and each gap for exactly `off_len` cycles.
- Total timed sequence length: n·on + (n−1)·off cycles.
- `done` and the `state_over` 1→0 transition occur on the edge where `off_on` falls after the last pulse.
- `stop` sampled at edge k: `off_on`=0 and `done`=1 after edge k.
- `arm` deasserted mid-pulse: outputs return to reset values after the next edge. No `done` pulse is produced.

## Structure
- Shared package `off_on_pkg` holds:
  - the state encoding constants (IDLE=2'b00, ON=2'b01, OFF=2'b10, DONE=2'b11);
  - the mode constants MODE_LEVEL=0 and MODE_TIMED=1.
- Sub-module `seg_timer` (parameter `CNT_W`): a loadable down-counter with a load strobe, load value, enable and a `zero` flag. It is used for both ON and OFF segments.
- `off_on_seq` contains the state register, next-state logic, latched configuration, pulse counter and output registers.

## Test plan
- `mode`=0, arm at cycle 10, `stop` at cycle 40 → `off_on` high for cycles 11–40, `done` pulse at 41, `state_over`=0 from 41, `pulse_cnt`=1.
- `mode`=1, `on_len`=3, `off_len`=2, `n_pulse`=3 → ON/OFF pattern 3-2-3-2-3 (13 cycles), then `done`, `pulse_cnt`=3.
- `mode`=1 with `on_len`=0, `off_len`=0, `n_pulse`=0 → a single 1-cycle pulse, then DONE.
- `mode`=1, `on_len`=5, `n_pulse`=4, `stop` during the second OFF gap → `off_on` stays 0, DONE on the next edge, `pulse_cnt`=2.
- `arm` dropped in the middle of the second ON phase → next edge returns all outputs to reset values, `state_over`=1, no `done`. Re-arming restarts from `pulse_cnt`=0.
- `rst` asserted while `arm`=1 in OFF → IDLE with reset outputs. Release of `rst` with `arm` still high restarts the sequence one cycle later.

Source files
------------

// File: rtl/off_on_pkg.sv
// Shared types for the NMR gate sequencer:
// state encoding and gate mode constants.
package off_on_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ON   = 2'b01,
        ST_OFF  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_TIMED = 1'b1;

endpackage

// File: rtl/off_on_seq_if.sv
// Control/status bundle between the acquisition
// sequencer (master) and the gate sequencer (slave).
interface off_on_seq_if #(
    parameter int CNT_W = 16,
    parameter int NP_W  = 8
);
    logic             arm;
    logic             stop;
    logic             mode;
    logic [CNT_W-1:0] on_len;
    logic [CNT_W-1:0] off_len;
    logic [NP_W-1:0]  n_pulse;
    logic             off_on;
    logic             state_over;
    logic             done;
    logic             busy;
    logic [NP_W-1:0]  pulse_cnt;

    modport master (
        output arm, stop, mode,
        output on_len, off_len, n_pulse,
        input  off_on, state_over, done,
        input  busy, pulse_cnt
    );

    modport slave (
        input  arm, stop, mode,
        input  on_len, off_len, n_pulse,
        output off_on, state_over, done,
        output busy, pulse_cnt
    );
endinterface

// File: rtl/off_on_seq_seg_timer.sv
// Loadable down-counter timing one ON or OFF
// segment; zero flags the last cycle of a segment.
module seg_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk_sys,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_zero
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/off_on_seq.sv
// Gate sequencer: level gate or timed ON/OFF pulse
// train, with registered gate, completion and count.
module off_on_seq
    import off_on_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int NP_W  = 8
) (
    input  logic       clk_sys,
    input  logic       rst,
    off_on_seq_if.slave bus
);
    state_t           r_state;
    state_t           w_nxt;
    logic             r_mode;
    logic [CNT_W-1:0] r_on;
    logic [CNT_W-1:0] r_off;
    logic [NP_W-1:0]  r_np;
    logic [NP_W-1:0]  r_pcnt;
    logic             r_off_on;
    logic             r_over;
    logic             r_done;
    logic             r_busy;

    logic             w_ld;
    logic [CNT_W-1:0] w_ld_val;
    logic             w_en;
    logic             w_zero;
    logic             w_inc;
    logic             w_start;
    logic             w_last;
    logic [CNT_W-1:0] w_on_in;
    logic [CNT_W-1:0] w_off_in;
    logic [NP_W-1:0]  w_np_in;
    logic [NP_W:0]    w_pc_nx;

    // Zero-length fields behave as one
    assign w_on_in  = (bus.on_len == '0)
                    ? CNT_W'(1) : bus.on_len;
    assign w_off_in = (bus.off_len == '0)
                    ? CNT_W'(1) : bus.off_len;
    assign w_np_in  = (bus.n_pulse == '0)
                    ? NP_W'(1) : bus.n_pulse;

    assign w_pc_nx = {1'b0, r_pcnt}
                   + {{NP_W{1'b0}}, 1'b1};
    assign w_last  = (w_pc_nx == {1'b0, r_np});

    seg_timer #(.CNT_W(CNT_W)) u_timer (
        .clk_sys    (clk_sys),
        .rst        (rst),
        .i_load     (w_ld),
        .i_load_val (w_ld_val),
        .i_en       (w_en),
        .o_zero     (w_zero)
    );

    always_comb begin
        w_nxt    = r_state;
        w_ld     = 1'b0;
        w_ld_val = '0;
        w_en     = 1'b0;
        w_inc    = 1'b0;
        w_start  = 1'b0;
        if (!bus.arm) begin
            w_nxt = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.stop) begin
                        w_nxt = ST_DONE;
                    end else begin
                        w_nxt    = ST_ON;
                        w_start  = 1'b1;
                        w_ld     = 1'b1;
                        w_ld_val = w_on_in - CNT_W'(1);
                    end
                end
                ST_ON: begin
                    if (bus.stop) begin
                        w_nxt = ST_DONE;
                        w_inc = 1'b1;
                    end else if (r_mode == MODE_TIMED) begin
                        if (w_zero) begin
                            w_inc = 1'b1;
                            if (w_last) begin
                                w_nxt = ST_DONE;
                            end else begin
                                w_nxt    = ST_OFF;
                                w_ld     = 1'b1;
                                w_ld_val = r_off - CNT_W'(1);
                            end
                        end else begin
                            w_en = 1'b1;
                        end
                    end
                end
                ST_OFF: begin
                    if (bus.stop) begin
                        w_nxt = ST_DONE;
                    end else if (w_zero) begin
                        w_nxt    = ST_ON;
                        w_ld     = 1'b1;
                        w_ld_val = r_on - CNT_W'(1);
                    end else begin
                        w_en = 1'b1;
                    end
                end
                ST_DONE: w_nxt = ST_DONE;
                default: w_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_off_on <= 1'b0;
            r_over   <= 1'b1;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_pcnt   <= '0;
            r_mode   <= MODE_LEVEL;
            r_on     <= CNT_W'(1);
            r_off    <= CNT_W'(1);
            r_np     <= NP_W'(1);
        end else begin
            r_state  <= w_nxt;
            r_off_on <= (w_nxt == ST_ON);
            r_over   <= (w_nxt != ST_DONE);
            r_done   <= (w_nxt == ST_DONE)
                     && (r_state != ST_DONE);
            r_busy   <= (w_nxt == ST_ON)
                     || (w_nxt == ST_OFF);
            if (w_nxt == ST_IDLE) begin
                r_pcnt <= '0;
            end else if (w_inc && !w_pc_nx[NP_W]) begin
                r_pcnt <= w_pc_nx[NP_W-1:0];
            end
            if (w_start) begin
                r_mode <= bus.mode;
                r_on   <= w_on_in;
                r_off  <= w_off_in;
                r_np   <= w_np_in;
            end
        end
    end

    assign bus.off_on     = r_off_on;
    assign bus.state_over = r_over;
    assign bus.done       = r_done;
    assign bus.busy       = r_busy;
    assign bus.pulse_cnt  = r_pcnt;
endmodule

// File: tb/tb_off_on_seq.sv
// Bench for off_on_seq: directed scenarios plus random
// stimulus against a timeline-based reference model.
module tb_off_on_seq;
    localparam int CNT_W = 16;
    localparam int NP_W  = 8;

    logic clk_sys = 1'b0;
    logic rst     = 1'b1;
    always #5 clk_sys = ~clk_sys;

    off_on_seq_if #(.CNT_W(CNT_W), .NP_W(NP_W)) bus();

    off_on_seq #(.CNT_W(CNT_W), .NP_W(NP_W)) dut (
        .clk_sys (clk_sys),
        .rst     (rst),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: position in the sequence timeline
    bit     m_started = 0;
    bit     m_run = 0;
    bit     m_fin = 0;
    bit     m_mode = 0;
    longint m_on = 1, m_off = 1, m_n = 1;
    longint m_e = 0;
    bit     x_off_on = 0, x_over = 1;
    bit     x_done = 0, x_busy = 0;
    int     x_pc = 0;

    function automatic bit in_on(longint e);
        if (!m_mode) return 1'b1;
        return (e % (m_on + m_off)) < m_on;
    endfunction

    function automatic int completed(longint e);
        longint p = m_on + m_off;
        return int'(e / p) + (((e % p) >= m_on) ? 1 : 0);
    endfunction

    always @(posedge clk_sys) begin
        m_started = 1;
        x_done = 0;
        if (rst || !bus.arm) begin
            m_run = 0;
            m_fin = 0;
            x_pc  = 0;
        end else if (m_fin) begin
            x_done = 0;
        end else if (!m_run) begin
            if (bus.stop) begin
                m_fin  = 1;
                x_done = 1;
                x_pc   = 0;
            end else begin
                m_run  = 1;
                m_e    = 0;
                m_mode = bus.mode;
                m_on   = (bus.on_len == 0) ? 1 : longint'(bus.on_len);
                m_off  = (bus.off_len == 0) ? 1 : longint'(bus.off_len);
                m_n    = (bus.n_pulse == 0) ? 1 : longint'(bus.n_pulse);
                x_pc   = 0;
            end
        end else if (bus.stop) begin
            m_run  = 0;
            m_fin  = 1;
            x_done = 1;
            x_pc   = m_mode ? completed(m_e) + int'(in_on(m_e)) : 1;
            if (x_pc > 255) x_pc = 255;
        end else if (m_mode && (m_e + 1 == m_n * m_on + (m_n - 1) * m_off)) begin
            m_run  = 0;
            m_fin  = 1;
            x_done = 1;
            x_pc   = int'(m_n);
        end else begin
            m_e  = m_e + 1;
            x_pc = m_mode ? completed(m_e) : 0;
        end
        x_off_on = m_run && in_on(m_e);
        x_busy   = m_run;
        x_over   = !m_fin;
    end

    always @(negedge clk_sys) begin
        if (m_started) begin
            n_checks++;
            if (bus.off_on !== x_off_on || bus.state_over !== x_over ||
                bus.done !== x_done || bus.busy !== x_busy ||
                bus.pulse_cnt !== NP_W'(x_pc)) begin
                n_errors++;
                $display("FAIL model t=%0t got off_on=%b over=%b done=%b busy=%b cnt=%0d exp %b %b %b %b %0d",
                         $time, bus.off_on, bus.state_over, bus.done,
                         bus.busy, bus.pulse_cnt, x_off_on, x_over,
                         x_done, x_busy, x_pc);
            end
        end
    end

    task automatic chk(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s got %0d exp %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_sys);
    endtask

    task automatic idle2();
        bus.arm = 0;
        bus.stop = 0;
        rst = 0;
        repeat (2) tick();
    endtask

    task automatic cfg(bit md, int on, int off, int n);
        bus.mode    = md;
        bus.on_len  = CNT_W'(on);
        bus.off_len = CNT_W'(off);
        bus.n_pulse = NP_W'(n);
    endtask

    // Runs until done; returns done tick and pattern
    task automatic run_to_done(output int dn, output int pat);
        dn = 0;
        pat = 0;
        for (int i = 1; i <= 60 && dn == 0; i++) begin
            tick();
            if (bus.done) dn = i;
            else pat = (pat << 1) | int'(bus.off_on);
        end
    endtask

    int hi, dn, pat;

    initial begin
        bus.arm = 0;
        bus.stop = 0;
        cfg(0, 1, 1, 1);
        repeat (3) tick();
        chk("rst_off_on", int'(bus.off_on), 0);
        chk("rst_over", int'(bus.state_over), 1);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_cnt", int'(bus.pulse_cnt), 0);
        idle2();

        cfg(0, 7, 7, 7);
        bus.arm = 1;
        hi = 0;
        repeat (30) begin
            tick();
            if (bus.off_on) hi++;
        end
        chk("level_hi_cycles", hi, 30);
        bus.stop = 1;
        tick();
        chk("level_done", int'(bus.done), 1);
        chk("level_off", int'(bus.off_on), 0);
        chk("level_over", int'(bus.state_over), 0);
        chk("level_cnt", int'(bus.pulse_cnt), 1);
        bus.stop = 0;
        tick();
        chk("level_done_1cyc", int'(bus.done), 0);
        idle2();

        cfg(1, 3, 2, 3);
        bus.arm = 1;
        run_to_done(dn, pat);
        chk("train_done_tick", dn, 14);
        chk("train_pattern", pat, 32'h1CE7);
        chk("train_cnt", int'(bus.pulse_cnt), 3);
        idle2();

        cfg(1, 0, 0, 0);
        bus.arm = 1;
        run_to_done(dn, pat);
        chk("zero_done_tick", dn, 2);
        chk("zero_pattern", pat, 1);
        chk("zero_cnt", int'(bus.pulse_cnt), 1);
        idle2();

        cfg(1, 5, 4, 4);
        bus.arm = 1;
        repeat (16) tick();
        chk("gap2_in_off", int'(bus.off_on), 0);
        bus.stop = 1;
        tick();
        chk("gap2_done", int'(bus.done), 1);
        chk("gap2_cnt", int'(bus.pulse_cnt), 2);
        idle2();

        cfg(1, 3, 2, 3);
        bus.arm = 1;
        repeat (7) tick();
        chk("drop_mid_on", int'(bus.off_on), 1);
        bus.arm = 0;
        tick();
        chk("drop_off_on", int'(bus.off_on), 0);
        chk("drop_over", int'(bus.state_over), 1);
        chk("drop_no_done", int'(bus.done), 0);
        chk("drop_cnt", int'(bus.pulse_cnt), 0);
        bus.arm = 1;
        tick();
        chk("rearm_on", int'(bus.off_on), 1);
        chk("rearm_cnt", int'(bus.pulse_cnt), 0);
        run_to_done(dn, pat);
        chk("rearm_done_tick", dn, 13);
        chk("rearm_final_cnt", int'(bus.pulse_cnt), 3);
        idle2();

        cfg(1, 3, 2, 3);
        bus.arm = 1;
        repeat (4) tick();
        chk("rst_in_off_busy", int'(bus.busy), 1);
        rst = 1;
        tick();
        chk("rst_mid_off_on", int'(bus.off_on), 0);
        chk("rst_mid_busy", int'(bus.busy), 0);
        chk("rst_mid_over", int'(bus.state_over), 1);
        rst = 0;
        tick();
        chk("rst_restart_on", int'(bus.off_on), 1);
        idle2();

        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (!bus.arm) bus.arm = ($urandom_range(0, 3) != 0);
            else bus.arm = ($urandom_range(0, 59) != 0);
            bus.stop    = ($urandom_range(0, 39) == 0);
            bus.mode    = ($urandom_range(0, 5) != 0);
            bus.on_len  = CNT_W'($urandom_range(0, 4));
            bus.off_len = CNT_W'($urandom_range(0, 4));
            bus.n_pulse = NP_W'($urandom_range(0, 4));
            tick();
        end
        idle2();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
